bpm_link_merge: RTL

BPM_LINK_MERGE -- requirements
Module: bpm_link_merge

---
 rtl/bpm_link_merge_if.sv | 28 ++
 rtl/bpm_link_merge.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/bpm_link_merge_if.sv
// rtl/bpm_link_merge_if.sv - link receive and merged BPM write bus for bpm_link_merge
// slave is the merge block's view; master is the link/buffer side.
interface bpm_link_merge_if #(
  parameter int INDEX_WIDTH = 9
);
  logic [1:0]             linkStrobe;
  logic [111:0]           link0Data;
  logic [111:0]           link1Data;
  logic [1:0]             linkStatusStrobe;
  logic [1:0]             link0StatusCode;
  logic [1:0]             link1StatusCode;
  logic                   wrStrobe;
  logic [INDEX_WIDTH-1:0] wrAddr;
  logic [111:0]           wrData;
  logic                   wrLink;

  modport master (
    output linkStrobe, link0Data, link1Data,
    output linkStatusStrobe, link0StatusCode, link1StatusCode,
    input  wrStrobe, wrAddr, wrData, wrLink
  );

  modport slave (
    input  linkStrobe, link0Data, link1Data,
    input  linkStatusStrobe, link0StatusCode, link1StatusCode,
    output wrStrobe, wrAddr, wrData, wrLink
  );
endinterface

// File: rtl/bpm_link_merge.sv
// rtl/bpm_link_merge.sv - two-link BPM packet merge with round-robin grant and statistics
// Optional per-cycle duplicate suppression enabled by defining BPM_LINK_MERGE_DEDUP_EN.
module bpm_link_merge #(
  parameter int INDEX_WIDTH = 9,
  parameter int BPM_COUNT   = 512
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cycleStart,
  bpm_link_merge_if.slave   bus,
  output logic [15:0]       link0GoodCount,
  output logic [15:0]       link1GoodCount,
  output logic [15:0]       link0BadCount,
  output logic [15:0]       link1BadCount,
  output logic [15:0]       link0DropCount,
  output logic [15:0]       link1DropCount
);

  localparam logic [INDEX_WIDTH:0] COUNT_L = (INDEX_WIDTH + 1)'(BPM_COUNT);

  logic [1:0]             slot_valid;
  logic [111:0]           slot_data [2];
  logic                   last_grant;

  logic [111:0]           link_data [2];
  logic [1:0]             status_code [2];
  logic [15:0]            good_cnt [2];
  logic [15:0]            bad_cnt [2];
  logic [15:0]            drop_cnt [2];

  logic                   grant_valid;
  logic                   grant_link;
  logic [1:0]             grant_vec;
  logic [111:0]           grant_data;
  logic [INDEX_WIDTH-1:0] grant_idx;
  logic                   in_range;
  logic                   dup;
  logic                   do_write;
  logic                   discard;
  logic [1:0]             drop_inc;

  always_comb begin
    link_data[0]   = bus.link0Data;
    link_data[1]   = bus.link1Data;
    status_code[0] = bus.link0StatusCode;
    status_code[1] = bus.link1StatusCode;
  end

  assign link0GoodCount = good_cnt[0];
  assign link1GoodCount = good_cnt[1];
  assign link0BadCount  = bad_cnt[0];
  assign link1BadCount  = bad_cnt[1];
  assign link0DropCount = drop_cnt[0];
  assign link1DropCount = drop_cnt[1];

  // Round-robin between two slots: on a tie the link not granted last time wins.
  always_comb begin
    grant_valid = |slot_valid;
    grant_link  = 1'b0;
    if (&slot_valid) begin
      grant_link = ~last_grant;
    end else if (slot_valid[1]) begin
      grant_link = 1'b1;
    end
    grant_vec  = {grant_valid & grant_link, grant_valid & ~grant_link};
    grant_data = slot_data[grant_link];
    grant_idx  = grant_data[96 +: INDEX_WIDTH];
    in_range   = {1'b0, grant_idx} < COUNT_L;
  end

`ifdef BPM_LINK_MERGE_DEDUP_EN
  localparam int BW = (BPM_COUNT > 1) ? $clog2(BPM_COUNT) : 1;

  logic [BPM_COUNT-1:0] seen;
  logic [BPM_COUNT-1:0] seen_eff;
  logic [BW-1:0]        bm_idx;

  // A grant in the cycleStart cycle sees the already-cleared bitmap.
  always_comb begin
    seen_eff = cycleStart ? '0 : seen;
    bm_idx   = grant_idx[BW-1:0];
    dup      = seen_eff[bm_idx];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      seen <= '0;
    end else begin
      seen <= seen_eff;
      if (grant_valid && in_range) begin
        seen[bm_idx] <= 1'b1;
      end
    end
  end
`else
  logic unused_cycle_start;

  assign unused_cycle_start = cycleStart;
  assign dup                = 1'b0;
`endif

  always_comb begin
    do_write = grant_valid & in_range & ~dup;
    discard  = grant_valid & ~do_write;
    drop_inc = (bus.linkStrobe & slot_valid & ~grant_vec) | ({2{discard}} & grant_vec);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      slot_valid   <= '0;
      last_grant   <= 1'b1;
      bus.wrStrobe <= 1'b0;
      bus.wrAddr   <= '0;
      bus.wrData   <= '0;
      bus.wrLink   <= 1'b0;
      for (int n = 0; n < 2; n++) begin
        slot_data[n] <= '0;
        good_cnt[n]  <= '0;
        bad_cnt[n]   <= '0;
        drop_cnt[n]  <= '0;
      end
    end else begin
      bus.wrStrobe <= do_write;
      if (do_write) begin
        bus.wrAddr <= grant_idx;
        bus.wrData <= grant_data;
        bus.wrLink <= grant_link;
      end
      if (grant_valid) begin
        last_grant <= grant_link;
      end
      // A slot being granted this cycle can take a new packet at the same edge.
      for (int n = 0; n < 2; n++) begin
        if (bus.linkStrobe[n] && (!slot_valid[n] || grant_vec[n])) begin
          slot_valid[n] <= 1'b1;
          slot_data[n]  <= link_data[n];
        end else if (grant_vec[n]) begin
          slot_valid[n] <= 1'b0;
        end
        if (drop_inc[n]) begin
          drop_cnt[n] <= drop_cnt[n] + 16'd1;
        end
        if (bus.linkStatusStrobe[n]) begin
          if (status_code[n] == 2'd0) begin
            good_cnt[n] <= good_cnt[n] + 16'd1;
          end else begin
            bad_cnt[n] <= bad_cnt[n] + 16'd1;
          end
        end
      end
    end
  end

endmodule
